// File: rtl/datapath_core_param.sv
// Parametrised register-file datapath: ALU/shifter, NZVC PSW, MDR/MAR memory port, exec/done handshake.
// Define DATAPATH_MUL_EN to add the multi-cycle shift-add multiplier FSM and its HI register.
`timescale 1ns/1ps
module datapath_core_param #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int IDXW = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             exec,
    input  logic [3:0]       op,
    input  logic [IDXW-1:0]  a_idx,
    input  logic [IDXW-1:0]  b_idx,
    input  logic [1:0]       a_src,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic             wr_en,
    input  logic             psw_we,
    input  logic             mdr_from_s,
    input  logic             mdr_load,
    input  logic             mar_load,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic             busy,
    output logic             done,
    output logic [3:0]       psw
);

    typedef enum logic [3:0] {
        OP_PASS_A = 4'd0,  OP_ADD = 4'd1,  OP_ADC = 4'd2,  OP_SUB = 4'd3,
        OP_SBC    = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
        OP_LSL    = 4'd8,  OP_LSR = 4'd9,  OP_ASR = 4'd10, OP_ROL = 4'd11,
        OP_ROR    = 4'd12, OP_MUL = 4'd13
    } op_e;

    typedef struct packed {
        logic [IDXW-1:0] wr_idx;
        logic            wr_en;
        logic            psw_we;
        logic            mdr_from_s;
        logic            mar_load;
    } ctrl_t;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] mdr_q, mdr_d, mar_q, mar_d;
    logic [3:0]       psw_q, psw_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_val, b_val, hi_val;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v, alu_c, alu_ok, carry_in;
    logic [WIDTH:0]   arith, cin_w;

    logic             mul_en, mul_idle, mul_busy, mul_commit;
    logic [WIDTH-1:0] mul_res;
    logic [3:0]       mul_flags;
    ctrl_t            mul_ctrl, cur_ctrl, c_ctrl;

    logic             accept, start_mul, single, do_commit;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;

    assign cur_ctrl = '{wr_idx: wr_idx, wr_en: wr_en, psw_we: psw_we,
                        mdr_from_s: mdr_from_s, mar_load: mar_load};

    always_comb begin
        case (a_src)
            2'd0:    a_val = regs_q[a_idx];
            2'd1:    a_val = mdr_q;
            2'd2:    a_val = hi_val;
            default: a_val = '0;
        endcase
    end
    assign b_val = regs_q[b_idx];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_res  = a_val;
        alu_v    = 1'b0;
        alu_c    = psw_q[0];
        alu_ok   = 1'b1;
        carry_in = (op == OP_ADC || op == OP_SBC) ? psw_q[0] : 1'b0;
        cin_w    = {{WIDTH{1'b0}}, carry_in};
        arith    = '0;
        case (op)
            OP_PASS_A: ;
            OP_ADD, OP_ADC: begin
                arith   = {1'b0, a_val} + {1'b0, b_val} + cin_w;
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_v   = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (alu_res[WIDTH-1] != a_val[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                // Bit WIDTH of the extended difference is the borrow.
                arith   = {1'b0, a_val} - {1'b0, b_val} - cin_w;
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_v   = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (alu_res[WIDTH-1] != a_val[WIDTH-1]);
            end
            OP_AND: alu_res = a_val & b_val;
            OP_OR:  alu_res = a_val | b_val;
            OP_XOR: alu_res = a_val ^ b_val;
            OP_LSL: begin alu_res = {a_val[WIDTH-2:0], 1'b0};            alu_c = a_val[WIDTH-1]; end
            OP_LSR: begin alu_res = {1'b0, a_val[WIDTH-1:1]};            alu_c = a_val[0];       end
            OP_ASR: begin alu_res = {a_val[WIDTH-1], a_val[WIDTH-1:1]};  alu_c = a_val[0];       end
            OP_ROL: begin alu_res = {a_val[WIDTH-2:0], a_val[WIDTH-1]};  alu_c = a_val[WIDTH-1]; end
            OP_ROR: begin alu_res = {a_val[0], a_val[WIDTH-1:1]};        alu_c = a_val[0];       end
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        accept    = exec && mul_idle;
        start_mul = accept && mul_en && (op == OP_MUL);
        single    = accept && !start_mul;
        if (mul_commit) begin
            do_commit = 1'b1;
            res       = mul_res;
            flags     = mul_flags;
            c_ctrl    = mul_ctrl;
        end else begin
            do_commit = single && alu_ok;
            res       = alu_res;
            flags     = {alu_res[WIDTH-1], (alu_res == '0), alu_v, alu_c};
            c_ctrl    = cur_ctrl;
        end

        regs_d = regs_q;
        if (do_commit && c_ctrl.wr_en) regs_d[c_ctrl.wr_idx] = res;
        // A result bound for MDR takes priority over a simultaneous memory load.
        mdr_d = mdr_load ? mem_rdata : mdr_q;
        if (do_commit && c_ctrl.mdr_from_s) mdr_d = res;
        mar_d  = (do_commit && c_ctrl.mar_load) ? res : mar_q;
        psw_d  = (do_commit && c_ctrl.psw_we) ? flags : psw_q;
        done_d = single || mul_commit;
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            // NOTE: the register file is a small flop array, so it is cleared by reset like any other state.
            regs_q <= '{default: '0};
            mdr_q  <= '0;
            mar_q  <= '0;
            psw_q  <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
            regs_q <= regs_d;
            mdr_q  <= mdr_d;
            mar_q  <= mar_d;
            psw_q  <= psw_d;
            done_q <= done_d;
        end
    end

`ifdef DATAPATH_MUL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL_RUN, ST_MUL_DONE} state_t;
    localparam int CNTW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    ctrl_t            lat_q, lat_d;
    logic [WIDTH:0]   step_sum;

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        step_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        case (state_q)
            ST_IDLE: begin
                if (start_mul) begin
                    mcand_d  = a_val;
                    acc_hi_d = '0;
                    acc_lo_d = b_val;
                    cnt_d    = '0;
                    lat_d    = cur_ctrl;
                    state_d  = ST_MUL_RUN;
                end
            end
            ST_MUL_RUN: begin
                // Multiplier bits shift out of the low half as product bits shift in.
                acc_hi_d = step_sum[WIDTH:1];
                acc_lo_d = {step_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNTW'(WIDTH - 1)) state_d = ST_MUL_DONE;
            end
            ST_MUL_DONE: begin
                hi_d    = acc_hi_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
        end
    end

    assign mul_en     = 1'b1;
    assign mul_idle   = (state_q == ST_IDLE);
    assign mul_busy   = (state_q == ST_MUL_RUN);
    assign mul_commit = (state_q == ST_MUL_DONE);
    assign mul_res    = acc_lo_q;
    assign mul_flags  = {acc_hi_q[WIDTH-1], ({acc_hi_q, acc_lo_q} == '0), 1'b0, (acc_hi_q != '0)};
    assign mul_ctrl   = lat_q;
    assign hi_val     = hi_q;
`else
    assign mul_en     = 1'b0;
    assign mul_idle   = 1'b1;
    assign mul_busy   = 1'b0;
    assign mul_commit = 1'b0;
    assign mul_res    = '0;
    assign mul_flags  = '0;
    assign mul_ctrl   = '0;
    assign hi_val     = '0;
`endif

    assign mem_wdata = mdr_q;
    assign mem_addr  = mar_q;
    assign busy      = mul_busy;
    assign done      = done_q;
    assign psw       = psw_q;

endmodule

// File: tb/tb_datapath_core_param.sv
// Directed bench for datapath_core_param (WIDTH=16, NREGS=8); MUL steps follow DATAPATH_MUL_EN.
`timescale 1ns/1ps
module tb_datapath_core_param;
    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int IDXW  = 3;

    localparam int OP_PASS_A = 0, OP_ADD = 1, OP_ADC = 2, OP_SUB = 3, OP_SBC = 4, OP_AND = 5;
    localparam int OP_LSL = 8, OP_ASR = 10, OP_ROR = 12, OP_MUL = 13, OP_RSV = 14;

    logic             CLK, CLR, exec, wr_en, psw_we, mdr_from_s, mdr_load, mar_load;
    logic [3:0]       op;
    logic [IDXW-1:0]  a_idx, b_idx, wr_idx;
    logic [1:0]       a_src;
    logic [WIDTH-1:0] mem_rdata, mem_wdata, mem_addr;
    logic             busy, done;
    logic [3:0]       psw;

    int total = 0;
    int bad   = 0;
    int done_edge, busy_cnt, done_cnt;

    datapath_core_param #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .CLK(CLK), .CLR(CLR), .exec(exec), .op(op), .a_idx(a_idx), .b_idx(b_idx),
        .a_src(a_src), .wr_idx(wr_idx), .wr_en(wr_en), .psw_we(psw_we),
        .mdr_from_s(mdr_from_s), .mdr_load(mdr_load), .mar_load(mar_load),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
        .busy(busy), .done(done), .psw(psw)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        exec = 1'b0; op = '0; a_idx = '0; b_idx = '0; a_src = '0; wr_idx = '0;
        wr_en = 1'b0; psw_we = 1'b0; mdr_from_s = 1'b0; mdr_load = 1'b0; mar_load = 1'b0;
    endtask

    task automatic set_op(input int o, input int ai, input int bi, input int src, input int wi,
                          input int we, input int pwe, input int mfs, input int marl);
        op = 4'(o); a_idx = IDXW'(ai); b_idx = IDXW'(bi); a_src = 2'(src); wr_idx = IDXW'(wi);
        wr_en = 1'(we); psw_we = 1'(pwe); mdr_from_s = 1'(mfs); mar_load = 1'(marl);
        exec = 1'b1;
    endtask

    task automatic do_op(input int o, input int ai, input int bi, input int src, input int wi,
                         input int we, input int pwe, input int mfs, input int marl);
        set_op(o, ai, bi, src, wi, we, pwe, mfs, marl);
        tick();
        idle_inputs();
    endtask

    task automatic load_reg(input int idx, input logic [WIDTH-1:0] val);
        mem_rdata = val;
        mdr_load  = 1'b1;
        tick();
        mdr_load  = 1'b0;
        do_op(OP_PASS_A, 0, 0, 1, idx, 1, 0, 0, 0);
    endtask

    // Registers are observed through MAR via PASS_A with flags left untouched.
    task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
        do_op(OP_PASS_A, idx, 0, 0, 0, 0, 0, 0, 1);
        check(tag, 32'(mem_addr), exp);
    endtask

    task automatic clear_c();
        do_op(OP_SUB, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        CLR = 1'b0;
        mem_rdata = '0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_psw", 32'(psw), 'h0);
        check("rst_addr", 32'(mem_addr), 'h0);
        check("rst_wdata", 32'(mem_wdata), 'h0);
        check("rst_busy", 32'(busy), 'h0);
        check("rst_done", 32'(done), 'h0);
        CLR = 1'b1;

        do_op(OP_PASS_A, 0, 0, 3, 0, 1, 1, 0, 0);
        check("pass_zero_done", 32'(done), 'h1);
        check("pass_zero_psw", 32'(psw), 'b0100);
        tick();
        check("done_one_cycle", 32'(done), 'h0);
        check_reg("r0_zero", 0, 'h0);

        load_reg(1, 16'h7FFF);
        load_reg(2, 16'h0001);
        do_op(OP_ADD, 1, 2, 0, 3, 1, 1, 0, 0);
        check("add_psw", 32'(psw), 'b1010);
        check_reg("add_res", 3, 'h8000);

        load_reg(4, 16'h1111);
        do_op(OP_SUB, 3, 3, 0, 4, 1, 1, 0, 0);
        check("sub_psw", 32'(psw), 'b0100);
        check_reg("sub_res", 4, 'h0000);

        load_reg(5, 16'h8000);
        load_reg(6, 16'h2222);
        do_op(OP_LSL, 5, 0, 0, 6, 1, 1, 0, 0);
        check("lsl_psw", 32'(psw), 'b0101);
        check_reg("lsl_res", 6, 'h0000);

        load_reg(1, 16'h00F0);
        load_reg(2, 16'h0FF0);
        do_op(OP_AND, 1, 2, 0, 3, 1, 1, 0, 0);
        check("and_psw_keeps_c", 32'(psw), 'b0001);
        check_reg("and_res", 3, 'h00F0);

        do_op(OP_RSV, 1, 2, 0, 7, 1, 1, 1, 1);
        check("rsv_done", 32'(done), 'h1);
        check("rsv_psw", 32'(psw), 'b0001);
        check("rsv_mar", 32'(mem_addr), 'h00F0);
        check_reg("rsv_no_write", 7, 'h0000);

        load_reg(1, 16'hFFFF);
        load_reg(2, 16'h0000);
        do_op(OP_ADC, 1, 2, 0, 3, 1, 1, 0, 0);
        check("adc_psw", 32'(psw), 'b0101);
        check_reg("adc_res", 3, 'h0000);
        do_op(OP_SBC, 2, 2, 0, 3, 1, 1, 0, 0);
        check("sbc_psw", 32'(psw), 'b1001);
        check_reg("sbc_res", 3, 'hFFFF);

        load_reg(1, 16'h8001);
        clear_c();
        do_op(OP_ASR, 1, 0, 0, 3, 1, 1, 0, 0);
        check("asr_psw", 32'(psw), 'b1001);
        check_reg("asr_res", 3, 'hC000);

        load_reg(1, 16'h0001);
        clear_c();
        do_op(OP_ROR, 1, 0, 0, 3, 1, 1, 0, 0);
        check("ror_psw", 32'(psw), 'b1001);
        check_reg("ror_res", 3, 'h8000);

        mem_rdata = 16'hBEEF;
        mdr_load  = 1'b1;
        tick();
        mdr_load  = 1'b0;
        check("mdr_load", 32'(mem_wdata), 'hBEEF);
        do_op(OP_PASS_A, 0, 0, 1, 0, 0, 0, 0, 1);
        check("mar_from_mdr", 32'(mem_addr), 'hBEEF);
        load_reg(4, 16'h5555);
        mem_rdata = 16'hAAAA;
        mdr_load  = 1'b1;
        do_op(OP_PASS_A, 4, 0, 0, 0, 0, 0, 1, 0);
        check("mdr_result_wins", 32'(mem_wdata), 'h5555);
        check("psw_hold_no_we", 32'(psw), 'b1001);

`ifdef DATAPATH_MUL_EN
        load_reg(1, 16'h1234);
        load_reg(2, 16'h5678);
        done_edge = 0;
        set_op(OP_MUL, 1, 2, 0, 6, 1, 1, 0, 0);
        tick();
        idle_inputs();
        check("mul_busy_start", 32'(busy), 'h1);
        check("mul_no_early_done", 32'(done), 'h0);
        busy_cnt = int'(busy);
        for (int e = 2; e <= 40; e++) begin
            tick();
            if (done) begin
                done_edge = e;
                break;
            end
            busy_cnt += int'(busy);
            if (e == 3) set_op(OP_ADD, 1, 2, 0, 7, 1, 0, 0, 0);
            else idle_inputs();
        end
        idle_inputs();
        check("mul_done_edge", 32'(done_edge), 'd18);
        check("mul_busy_cycles", 32'(busy_cnt), 'd16);
        check("mul_busy_at_done", 32'(busy), 'h0);
        check("mul_psw", 32'(psw), 'b0001);
        check_reg("mul_low", 6, 'h0060);
        do_op(OP_PASS_A, 0, 0, 2, 0, 0, 0, 0, 1);
        check("mul_hi", 32'(mem_addr), 'h0626);
        check_reg("mul_exec_ignored", 7, 'h0000);

        load_reg(1, 16'h0003);
        load_reg(2, 16'h0004);
        do_op(OP_MUL, 1, 2, 0, 5, 1, 1, 0, 0);
        repeat (5) tick();
        #2;
        CLR = 1'b0;
        #1;
        check("mul_abort_busy", 32'(busy), 'h0);
        check("mul_abort_done", 32'(done), 'h0);
        tick();
        CLR = 1'b1;
        done_cnt = 0;
        repeat (25) begin
            tick();
            done_cnt += int'(done);
        end
        check("mul_abort_no_done", 32'(done_cnt), 'd0);
        check_reg("mul_abort_no_write", 5, 'h0000);
        do_op(OP_PASS_A, 0, 0, 2, 0, 0, 0, 0, 1);
        check("mul_abort_hi", 32'(mem_addr), 'h0000);
        do_op(OP_ROR, 1, 0, 0, 0, 0, 1, 0, 0);
`else
        load_reg(1, 16'h1234);
        load_reg(2, 16'h5678);
        do_op(OP_MUL, 1, 2, 0, 6, 1, 1, 0, 0);
        check("mul_off_done", 32'(done), 'h1);
        check("mul_off_busy", 32'(busy), 'h0);
        check("mul_off_psw", 32'(psw), 'b1001);
        check_reg("mul_off_no_write", 6, 'h0000);
        do_op(OP_PASS_A, 0, 0, 2, 0, 0, 0, 0, 1);
        check("hi_reads_zero", 32'(mem_addr), 'h0000);
`endif

        load_reg(5, 16'h1234);
        check_reg("r5_pre_reset", 5, 'h1234);
        set_op(OP_PASS_A, 5, 0, 0, 3, 1, 1, 0, 1);
        #2;
        CLR = 1'b0;
        #1;
        check("clr_wdata", 32'(mem_wdata), 'h0);
        check("clr_addr", 32'(mem_addr), 'h0);
        check("clr_psw", 32'(psw), 'h0);
        check("clr_busy", 32'(busy), 'h0);
        check("clr_done", 32'(done), 'h0);
        tick();
        idle_inputs();
        CLR = 1'b1;
        check_reg("clr_r5", 5, 'h0000);
        do_op(OP_PASS_A, 0, 0, 3, 0, 1, 1, 0, 0);
        check("clr_pass_z", 32'(psw), 'b0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
